// File: rtl/imem_responder_pkg.sv
// Shared core definitions for the instruction-memory responder: instruction
// and address widths, the substituted NOP, fault encoding and the entry
// types that move through the fetch return path.
package imem_responder_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INST_W = 32;

    // addi x0, x0, 0 -- delivered for faulted, flushed or empty slots.
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    // Bit 0 flags a misaligned pc, bit 1 an address beyond the memory.
    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10,
        FAULT_BOTH     = 2'b11
    } fault_e;

    // A fetch that has been accepted and whose memory read is in progress.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        fault_e          fault;
    } fetch_t;

    // A completed fetch, ready for decode.
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              fault;
    } resp_t;

    // Classify a fetch address. The range test uses the whole word address,
    // so addresses above the memory never alias onto low words.
    function automatic fault_e classify_pc(input logic [XLEN-1:0] pc,
                                           input int unsigned     depth_words);
        logic misaligned;
        logic out_of_range;
        misaligned   = (pc[1:0] != 2'b00);
        out_of_range = ({2'b00, pc[XLEN-1:2]} >= depth_words);
        return fault_e'({out_of_range, misaligned});
    endfunction

endpackage

// File: rtl/imem_sram.sv
// Single-port synchronous instruction RAM. A write takes the port for the
// cycle; a read returns data on the following cycle and the read register
// keeps its value until the next read, so a stalled consumer can still pick
// it up later.
module imem_sram
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [INST_W-1:0] wdata,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [DEPTH_WORDS];

    // Write when enabled with we, otherwise read into the output register.
    // NOTE: storage and its read register carry no reset -- a RAM macro has
    // none, and program contents must survive a core reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder between the fetch stage and decode. Accepted
// pcs enter an in-flight slot while the RAM reads; the result is shown to
// decode straight from that slot (one-cycle latency). When decode stalls,
// the shown entry is parked in a hold register and one further return can
// land in a skid entry; order is always hold, skid, in-flight.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter logic [INST_W-1:0] NOP_INST    = imem_responder_pkg::NOP_INST,
    localparam int unsigned      AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   if_pc_i,
    output logic              rom_ready_o,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              ld_en_i,
    input  logic [AW-1:0]     ld_addr_i,
    input  logic [INST_W-1:0] ld_data_i,
    output logic              rom_valid_o,
    output logic [INST_W-1:0] rom_inst_o,
    output logic [XLEN-1:0]   rom_pc_o,
    output logic              rom_fault_o
);

    localparam fetch_t FETCH_EMPTY = '{valid: 1'b0, pc: '0, fault: FAULT_NONE};
    localparam resp_t  RESP_EMPTY  = '{valid: 1'b0, pc: '0, inst: NOP_INST, fault: 1'b0};

    fetch_t            inflight_q, inflight_d;
    resp_t             hold_q, hold_d;
    resp_t             skid_q, skid_d;
    logic              ready_en_q;

    fetch_t            new_fetch;
    resp_t             inflight_resp;
    resp_t             shown;
    fault_e            pc_fault;
    logic              accept;
    logic              rd_en;
    logic [AW-1:0]     sram_addr;
    logic [INST_W-1:0] sram_rdata;

    // Acceptance: blocked while the skid is occupied, while loading, and in
    // the first cycle out of reset; a flush drops the pc presented with it.
    assign pc_fault    = classify_pc(if_pc_i, DEPTH_WORDS);
    assign rom_ready_o = ready_en_q & ~skid_q.valid & ~ld_en_i;
    assign accept      = rom_ready_o & ~flush_i;
    assign rd_en       = accept & (pc_fault == FAULT_NONE);

    // Loads own the single port; faulted fetches never touch memory.
    assign sram_addr = ld_en_i ? ld_addr_i : if_pc_i[AW+1:2];

    imem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_sram (
        .clk   (clk),
        .en    (ld_en_i | rd_en),
        .we    (ld_en_i),
        .addr  (sram_addr),
        .wdata (ld_data_i),
        .rdata (sram_rdata)
    );

    // Build the entry a newly accepted pc would occupy.
    always_comb begin
        new_fetch       = FETCH_EMPTY;
        new_fetch.valid = accept;
        new_fetch.pc    = if_pc_i;
        new_fetch.fault = accept ? pc_fault : FAULT_NONE;
    end

    // Combine the in-flight slot with the data the RAM returned for it.
    always_comb begin
        inflight_resp       = RESP_EMPTY;
        inflight_resp.valid = inflight_q.valid;
        inflight_resp.pc    = inflight_q.pc;
        if (inflight_q.valid) begin
            inflight_resp.fault = (inflight_q.fault != FAULT_NONE);
            inflight_resp.inst  = inflight_resp.fault ? NOP_INST : sram_rdata;
        end
    end

    // Advance hold/skid/in-flight; a flush empties every slot.
    // NOTE: every target gets its current value first, so no path through
    // the branches below can leave one unassigned and infer a latch.
    always_comb begin
        inflight_d = inflight_q;
        hold_d     = hold_q;
        skid_d     = skid_q;
        if (flush_i) begin
            inflight_d = FETCH_EMPTY;
            hold_d     = RESP_EMPTY;
            skid_d     = RESP_EMPTY;
        end else if (hold_q.valid) begin
            if (stall_i) begin
                if (!inflight_q.valid) begin
                    inflight_d = new_fetch;
                end else if (!skid_q.valid) begin
                    skid_d     = inflight_resp;
                    inflight_d = new_fetch;
                end
                // Skid full: the in-flight entry waits; the RAM read
                // register holds its data because no read is issued.
            end else if (skid_q.valid) begin
                hold_d     = skid_q;
                skid_d     = inflight_resp;
                inflight_d = new_fetch;
            end else begin
                hold_d     = inflight_resp;
                inflight_d = new_fetch;
            end
        end else begin
            if (stall_i && inflight_q.valid) begin
                hold_d = inflight_resp;
            end
            inflight_d = new_fetch;
        end
    end

    // State registers; reset discards every pending fetch.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values sampled before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            inflight_q <= FETCH_EMPTY;
            hold_q     <= RESP_EMPTY;
            skid_q     <= RESP_EMPTY;
        end else begin
            ready_en_q <= 1'b1;
            inflight_q <= inflight_d;
            hold_q     <= hold_d;
            skid_q     <= skid_d;
        end
    end

    // Decode sees the oldest pending entry; empty slots read as NOP.
    always_comb begin
        shown       = hold_q.valid ? hold_q : inflight_resp;
        rom_valid_o = shown.valid;
        rom_pc_o    = shown.pc;
        rom_inst_o  = shown.valid ? shown.inst : NOP_INST;
        rom_fault_o = shown.valid & shown.fault;
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: streaming, stall/skid, faults, flush,
// program load and mid-stream reset, one cycle at a time.
module tb_imem_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc_i;
    logic        rom_ready_o;
    logic        flush_i;
    logic        stall_i;
    logic        ld_en_i;
    logic [9:0]  ld_addr_i;
    logic [31:0] ld_data_i;
    logic        rom_valid_o;
    logic [31:0] rom_inst_o;
    logic [31:0] rom_pc_o;
    logic        rom_fault_o;

    int n_assert = 0;
    int n_fail   = 0;

    imem_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_pc_i     (if_pc_i),
        .rom_ready_o (rom_ready_o),
        .flush_i     (flush_i),
        .stall_i     (stall_i),
        .ld_en_i     (ld_en_i),
        .ld_addr_i   (ld_addr_i),
        .ld_data_i   (ld_data_i),
        .rom_valid_o (rom_valid_o),
        .rom_inst_o  (rom_inst_o),
        .rom_pc_o    (rom_pc_o),
        .rom_fault_o (rom_fault_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task automatic settle();
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] inst,
                              input logic [31:0] pc, input logic flt);
        check({tag, "_valid"}, 32'(rom_valid_o), 32'(v));
        check({tag, "_inst"},  rom_inst_o, inst);
        check({tag, "_fault"}, 32'(rom_fault_o), 32'(flt));
        if (v) check({tag, "_pc"}, rom_pc_o, pc);
    endtask

    task automatic expect_ready(input string tag, input logic r);
        check({tag, "_ready"}, 32'(rom_ready_o), 32'(r));
    endtask

    task automatic load_word(input logic [9:0] addr, input logic [31:0] data);
        tick();
        ld_en_i = 1'b1; ld_addr_i = addr; ld_data_i = data;
        settle();
        expect_ready("load", 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; if_pc_i = '0; flush_i = 1'b0; stall_i = 1'b0;
        ld_en_i = 1'b0; ld_addr_i = '0; ld_data_i = '0;

        // Reset state
        tick(); tick();
        expect_out("rst", 1'b0, NOP, 32'h0, 1'b0);
        check("rst_pc", rom_pc_o, 32'h0);
        expect_ready("rst", 1'b0);

        // Reset-exit cycle: not ready yet
        rst_n = 1'b1;
        settle();
        expect_ready("rst_exit", 1'b0);

        // Program load
        for (int i = 0; i < 8; i++) load_word(10'(i), 32'hA0 + 32'(i));
        load_word(10'd16, 32'hB0);

        // Streaming 0,4,8,12 with no stall
        tick(); ld_en_i = 1'b0; if_pc_i = 32'h0; settle();
        expect_ready("s0", 1'b1);
        expect_out("s0", 1'b0, NOP, 32'h0, 1'b0);
        tick(); if_pc_i = 32'h4;  settle(); expect_out("s1", 1'b1, 32'hA0, 32'h0, 1'b0);
        tick(); if_pc_i = 32'h8;  settle(); expect_out("s2", 1'b1, 32'hA1, 32'h4, 1'b0);
        tick(); if_pc_i = 32'hC;  settle(); expect_out("s3", 1'b1, 32'hA2, 32'h8, 1'b0);
        tick(); if_pc_i = 32'h10; settle(); expect_out("s4", 1'b1, 32'hA3, 32'hC, 1'b0);
        tick(); flush_i = 1'b1;   settle(); expect_out("s5", 1'b1, 32'hA4, 32'h10, 1'b0);

        // Stall for three cycles while pc 4 is shown
        tick(); flush_i = 1'b0; if_pc_i = 32'h0; settle();
        expect_out("f0", 1'b0, NOP, 32'h0, 1'b0);
        expect_ready("f0", 1'b1);
        tick(); if_pc_i = 32'h4; settle(); expect_out("t0", 1'b1, 32'hA0, 32'h0, 1'b0);
        tick(); if_pc_i = 32'h8; stall_i = 1'b1; settle(); expect_out("t1", 1'b1, 32'hA1, 32'h4, 1'b0);
        tick(); if_pc_i = 32'hC; settle();
        expect_out("t2", 1'b1, 32'hA1, 32'h4, 1'b0);
        expect_ready("t2", 1'b1);
        tick(); if_pc_i = 32'h10; settle();
        expect_out("t3", 1'b1, 32'hA1, 32'h4, 1'b0);
        expect_ready("t3_skidfull", 1'b0);
        tick(); stall_i = 1'b0; settle();
        expect_out("t4", 1'b1, 32'hA1, 32'h4, 1'b0);
        expect_ready("t4", 1'b0);
        tick(); settle();
        expect_out("t5", 1'b1, 32'hA2, 32'h8, 1'b0);
        expect_ready("t5", 1'b0);
        tick(); settle();
        expect_out("t6", 1'b1, 32'hA3, 32'hC, 1'b0);
        expect_ready("t6", 1'b1);
        tick(); flush_i = 1'b1; settle(); expect_out("t7", 1'b1, 32'hA4, 32'h10, 1'b0);

        // Flush while stalled with the skid full, then redirect to 0x40
        tick(); flush_i = 1'b0; if_pc_i = 32'h0; settle(); expect_out("k0", 1'b0, NOP, 32'h0, 1'b0);
        tick(); if_pc_i = 32'h4; stall_i = 1'b1; settle(); expect_out("k1", 1'b1, 32'hA0, 32'h0, 1'b0);
        tick(); if_pc_i = 32'h8; settle(); expect_out("k2", 1'b1, 32'hA0, 32'h0, 1'b0);
        tick(); if_pc_i = 32'hC; flush_i = 1'b1; settle();
        expect_ready("k3_skidfull", 1'b0);
        expect_out("k3", 1'b1, 32'hA0, 32'h0, 1'b0);
        tick(); flush_i = 1'b0; stall_i = 1'b0; if_pc_i = 32'h40; settle();
        expect_out("k4_after_flush", 1'b0, NOP, 32'h0, 1'b0);
        expect_ready("k4", 1'b1);
        tick(); flush_i = 1'b1; settle(); expect_out("k5_redirect", 1'b1, 32'hB0, 32'h40, 1'b0);

        // Misaligned and out-of-range fetches
        tick(); flush_i = 1'b0; if_pc_i = 32'h2; settle(); expect_out("x0", 1'b0, NOP, 32'h0, 1'b0);
        tick(); if_pc_i = 32'h1000;      settle(); expect_out("x1_misalign", 1'b1, NOP, 32'h2, 1'b1);
        tick(); if_pc_i = 32'h4000_0000; settle(); expect_out("x2_range", 1'b1, NOP, 32'h1000, 1'b1);
        tick(); if_pc_i = 32'h10;        settle(); expect_out("x3_highbit", 1'b1, NOP, 32'h4000_0000, 1'b1);
        tick(); flush_i = 1'b1;          settle(); expect_out("x4", 1'b1, 32'hA4, 32'h10, 1'b0);

        // Program load during streaming
        tick(); flush_i = 1'b0; if_pc_i = 32'h10; settle(); expect_out("l0", 1'b0, NOP, 32'h0, 1'b0);
        tick(); ld_en_i = 1'b1; ld_addr_i = 10'd5; ld_data_i = 32'hDEAD_BEEF; if_pc_i = 32'h14; settle();
        expect_ready("l1_load", 1'b0);
        expect_out("l1", 1'b1, 32'hA4, 32'h10, 1'b0);
        tick(); ld_en_i = 1'b0; settle();
        expect_out("l2_bubble", 1'b0, NOP, 32'h0, 1'b0);
        expect_ready("l2", 1'b1);
        tick(); if_pc_i = 32'h18; settle(); expect_out("l3_loaded", 1'b1, 32'hDEAD_BEEF, 32'h14, 1'b0);

        // Flush together with a load: write lands, everything cleared
        tick(); flush_i = 1'b1; ld_en_i = 1'b1; ld_addr_i = 10'd7; ld_data_i = 32'h7777_7777; settle();
        expect_ready("fl_load", 1'b0);
        expect_out("fl0", 1'b1, 32'hA6, 32'h18, 1'b0);
        tick(); flush_i = 1'b0; ld_en_i = 1'b0; if_pc_i = 32'h1C; settle();
        expect_out("fl1", 1'b0, NOP, 32'h0, 1'b0);

        // Mid-stream reset with the skid full
        tick(); if_pc_i = 32'h0; stall_i = 1'b1; settle();
        expect_out("fl2_loaded", 1'b1, 32'h7777_7777, 32'h1C, 1'b0);
        tick(); if_pc_i = 32'h4; settle(); expect_ready("r0", 1'b1);
        tick(); if_pc_i = 32'h8; settle();
        expect_ready("r1_skidfull", 1'b0);
        expect_out("r1", 1'b1, 32'h7777_7777, 32'h1C, 1'b0);
        rst_n = 1'b0; stall_i = 1'b0; if_pc_i = 32'h0;
        settle();
        expect_out("r2_async", 1'b0, NOP, 32'h0, 1'b0);
        check("r2_pc", rom_pc_o, 32'h0);
        expect_ready("r2", 1'b0);
        tick(); rst_n = 1'b1; settle();
        expect_ready("r3_exit", 1'b0);
        expect_out("r3", 1'b0, NOP, 32'h0, 1'b0);
        tick(); settle(); expect_ready("r4", 1'b1);
        tick(); if_pc_i = 32'h4; settle(); expect_out("r5_mem_kept", 1'b1, 32'hA0, 32'h0, 1'b0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL declare parameter DEPTH_WORDS, default 1024, number of 32-bit instruction words (power of two, 16..4096).
REQ-002 SHALL declare parameter NOP_INST, default 32'h00000013, instruction substituted on fault or flush.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 if_pc_i  input  32  fetch address from the fetch stage, sampled every cycle rom_ready_o=1.
REQ-006 rom_ready_o  output  1  responder can accept if_pc_i this cycle; fetch stage holds its pc while low.
REQ-007 flush_i  input  1  redirect (id jump or fnb jump); kills all unissued/undelivered fetches.
REQ-008 stall_i  input  1  decode not accepting; output bundle must hold.
REQ-009 ld_en_i / ld_addr_i[log2(DEPTH_WORDS)-1:0] / ld_data_i[31:0]  inputs  program-load write port.
REQ-010 rom_valid_o  output  1  rom_inst_o/rom_pc_o/rom_fault_o valid for decode.
REQ-011 rom_inst_o  output  32  instruction word.
REQ-012 rom_pc_o  output  32  address the instruction was fetched from.
REQ-013 rom_fault_o  output  1  fetch was misaligned (pc[1:0]!=0) or out of range (pc[31:2] >= DEPTH_WORDS).

Function
REQ-014 Memory SHALL be single-port, synchronous read: address presented cycle t, data available cycle t+1.
REQ-015 Accept condition: rom_ready_o & ~flush_i; accepted pc and fault flag SHALL be captured into an in-flight stage (valid, pc, fault).
REQ-016 Latency: with stall_i=0 an accepted pc SHALL appear on rom_*_o with rom_valid_o=1 exactly one cycle later; sustained throughput one instruction per cycle.
REQ-017 Faulted fetch SHALL not read memory and SHALL deliver rom_inst_o=NOP_INST, rom_fault_o=1.
REQ-018 Output register SHALL hold all rom_*_o values while rom_valid_o=1 and stall_i=1.
REQ-019 If in-flight data returns while output is stalled, it SHALL be captured into a one-entry skid buffer; skid entry is delivered (before any newer fetch) when stall_i drops.
REQ-020 rom_ready_o SHALL be 0 when skid buffer is full, when ld_en_i=1, or during the reset-exit cycle; otherwise 1.
REQ-021 ld_en_i=1 SHALL write ld_data_i to ld_addr_i that cycle; load has priority, no read issued; in-flight and buffered entries unaffected.
REQ-022 flush_i=1 SHALL, at the next edge, clear output valid, skid valid and in-flight valid, and SHALL drop if_pc_i of that cycle; rom_valid_o=0 the cycle after flush.
REQ-023 flush_i with stall_i simultaneous: flush wins; output cleared regardless of stall.
REQ-024 flush_i with ld_en_i simultaneous: write SHALL still occur; all valids cleared.
REQ-025 When rom_valid_o=0, rom_inst_o SHALL be NOP_INST and rom_fault_o 0.
REQ-026 Address index SHALL be pc[log2(DEPTH_WORDS)+1:2]; range check uses full pc[31:2], no wrap-around aliasing.

Reset
REQ-027 While rst_n=0: rom_valid_o=0, rom_inst_o=NOP_INST, rom_pc_o=0, rom_fault_o=0, rom_ready_o=0, skid and in-flight valid=0.
REQ-028 Memory contents SHALL NOT be reset; reset mid-operation discards all in-flight and buffered fetches.
REQ-029 rom_ready_o SHALL rise one cycle after rst_n deasserts; first accepted pc is 32'h0 from the fetch stage.

Structure
REQ-030 NOP_INST, instruction width and fault-code encoding SHALL live in the shared core package.
REQ-031 Storage SHALL be one sub-module imem_sram (single-port synchronous RAM, write-enable, DEPTH_WORDS param); control, skid buffer and fault logic in imem_responder.

Verification
REQ-032 Preload words 0..3 = 0xA0..0xA3, stream pc 0,4,8,12, stall_i=0 -> rom_valid_o from cycle 2, rom_inst_o 0xA0..0xA3 with rom_pc_o 0..12 on consecutive cycles.
REQ-033 Stream pc 0,4,8; stall_i=1 for 3 cycles while pc 4 is output -> output holds pc 4, rom_ready_o=0 once skid full, release delivers 8 then resumes, no loss or duplication.
REQ-034 Present pc 0x2 then pc 0x1000 (DEPTH_WORDS=1024) -> rom_fault_o=1, rom_inst_o=0x00000013 for both.
REQ-035 flush_i=1 while stalled with skid full, next pc 0x40 -> cycle after flush rom_valid_o=0; next delivery pc 0x40 only.
REQ-036 ld_en_i=1 writing 0xDEADBEEF to word 5 during streaming -> rom_ready_o=0 that cycle; later fetch of pc 0x14 returns 0xDEADBEEF.
REQ-037 Assert rst_n=0 mid-stream with skid full -> all outputs at reset values immediately; after release fetch of pc 0 returns preloaded 0xA0.
